// File: rtl/delay_line_mem.sv
// rtl/delay_line_mem.sv - circular delay-line memory with two registered read taps
// Optional macro WR_FWD_EN: a read coincident with a write sees the post-write state.
module delay_line_mem #(
  parameter int N = 8,
  parameter int M = 16
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [N-1:0]         wdata,
  input  logic                 rd_en,
  input  logic [$clog2(M)-1:0] dly0,
  input  logic [$clog2(M)-1:0] dly1,
  output logic [N-1:0]         rdata0,
  output logic [N-1:0]         rdata1,
  output logic                 rvalid,
  output logic                 rerr,
  output logic [$clog2(M):0]   count,
  output logic                 full
);

  localparam int AW = $clog2(M);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(M);

  logic [N-1:0]  mem_q [M];
  logic [N-1:0]  mem_d [M];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  rdata0_q, rdata0_d;
  logic [N-1:0]  rdata1_q, rdata1_d;
  logic          rvalid_q, rvalid_d;
  logic          rerr_q, rerr_d;

  logic          fwd;
  logic [AW-1:0] rd_base;
  logic [CW-1:0] rd_cnt;
  logic [AW-1:0] addr0, addr1;
  logic [N-1:0]  word0, word1;
  logic          err0, err1;

  // Pointer, occupancy and storage; clear wins over a same-cycle write.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      count_d = '0;
    end else if (wr_en) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
      if (count_q != CNT_MAX) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Read view: pre-write state, or post-write state when forwarding a live write.
  always_comb begin
`ifdef WR_FWD_EN
    fwd = wr_en & ~clear;
`else
    fwd = 1'b0;
`endif
    rd_base = fwd ? (wptr_q + AW'(1)) : wptr_q;
    rd_cnt  = (fwd && (count_q != CNT_MAX)) ? (count_q + CW'(1)) : count_q;
    addr0   = rd_base - AW'(1) - dly0;
    addr1   = rd_base - AW'(1) - dly1;
    word0   = (fwd && (addr0 == wptr_q)) ? wdata : mem_q[addr0];
    word1   = (fwd && (addr1 == wptr_q)) ? wdata : mem_q[addr1];
    err0    = ({1'b0, dly0} >= rd_cnt);
    err1    = ({1'b0, dly1} >= rd_cnt);
  end

  // Tap registers hold their last value when no read is issued.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rvalid_d = rd_en;
    rerr_d   = 1'b0;
    if (rd_en) begin
      rdata0_d = err0 ? '0 : word0;
      rdata1_d = err1 ? '0 : word1;
      rerr_d   = err0 | err1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q   <= '0;
      count_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign rvalid = rvalid_q;
  assign rerr   = rerr_q;
  assign count  = count_q;
  assign full   = (count_q == CNT_MAX);

endmodule

// File: tb/tb_delay_line_mem.sv
// tb/tb_delay_line_mem.sv - self-checking bench for delay_line_mem (N=8, M=16)
// Reference model keeps the sample history in a queue; honours WR_FWD_EN.
module tb_delay_line_mem;

  localparam int N  = 8;
  localparam int M  = 16;
  localparam int AW = 4;

  logic          Clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          wr_en;
  logic [N-1:0]  wdata;
  logic          rd_en;
  logic [AW-1:0] dly0, dly1;
  logic [N-1:0]  rdata0, rdata1;
  logic          rvalid, rerr;
  logic [AW:0]   count;
  logic          full;

  int checks = 0;
  int errors = 0;

  int unsigned  hist[$];
  logic [N-1:0] exp_r0 = '0;
  logic [N-1:0] exp_r1 = '0;
  logic         exp_v  = 1'b0;
  logic         exp_e  = 1'b0;

  always #5 Clk = ~Clk;

  delay_line_mem #(.N(N), .M(M)) dut (
    .Clk(Clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wdata(wdata),
    .rd_en(rd_en), .dly0(dly0), .dly1(dly1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid(rvalid), .rerr(rerr), .count(count), .full(full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample d steps back in history (optionally with a pending write appended).
  task automatic model_tap(input int d, input logic fw, input logic [N-1:0] wd,
                           output logic [N-1:0] val, output logic err);
    int unsigned tmp[$];
    int cnt;
    tmp = hist;
    if (fw) tmp.push_back(wd);
    cnt = (tmp.size() > M) ? M : tmp.size();
    if (d >= cnt) begin
      val = '0;
      err = 1'b1;
    end else begin
      val = tmp[tmp.size() - 1 - d][N-1:0];
      err = 1'b0;
    end
  endtask

  task automatic step(input logic wr, input logic [N-1:0] wd, input logic rd,
                      input int d0, input int d1, input logic clr);
    logic         fw;
    logic [N-1:0] v0, v1;
    logic         e0, e1;
    int           ec;
    wr_en = wr; wdata = wd; rd_en = rd; clear = clr;
    dly0 = AW'(d0); dly1 = AW'(d1);
`ifdef WR_FWD_EN
    fw = wr && !clr;
`else
    fw = 1'b0;
`endif
    if (rd) begin
      model_tap(d0, fw, wd, v0, e0);
      model_tap(d1, fw, wd, v1, e1);
      exp_r0 = v0; exp_r1 = v1; exp_e = e0 | e1; exp_v = 1'b1;
    end else begin
      exp_v = 1'b0; exp_e = 1'b0;
    end
    if (clr) hist.delete();
    else if (wr) begin
      hist.push_back(32'(wd));
      if (hist.size() > M) void'(hist.pop_front());
    end
    @(posedge Clk);
    #1;
    ec = (hist.size() > M) ? M : hist.size();
    check("rvalid", 32'(rvalid), 32'(exp_v));
    check("rerr",   32'(rerr),   32'(exp_e));
    check("rdata0", 32'(rdata0), 32'(exp_r0));
    check("rdata1", 32'(rdata1), 32'(exp_r1));
    check("count",  32'(count),  32'(ec));
    check("full",   32'(full),   32'(ec == M));
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; wr_en = 1'b0; wdata = '0;
    rd_en = 1'b0; dly0 = '0; dly1 = '0;
    repeat (2) @(posedge Clk);
    #3 reset = 1'b1;

    // Idle after reset
    step(1'b0, 8'h00, 1'b0, 0, 0, 1'b0);

    // Five samples, taps 0 and 4
    for (int i = 1; i <= 5; i++) step(1'b1, N'(i), 1'b0, 0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 4, 1'b0);
    check("req029_rdata0", 32'(rdata0), 32'd5);
    check("req029_rdata1", 32'(rdata1), 32'd1);
    check("req029_count",  32'(count),  32'd5);

    // Wrap past depth
    step(1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    for (int i = 1; i <= 20; i++) step(1'b1, N'(i), 1'b0, 0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 15, 0, 1'b0);
    check("req030_rdata0", 32'(rdata0), 32'd5);
    check("req030_rdata1", 32'(rdata1), 32'd20);
    check("req030_full",   32'(full),   32'd1);

    // Unfilled tap, then clear dropping a write
    step(1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    step(1'b1, 8'hA1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 0, 0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 5, 2, 1'b0);
    check("req031_rdata1", 32'(rdata1), 32'hA1);
    check("req031_rerr",   32'(rerr),   32'd1);
    step(1'b1, 8'h7F, 1'b1, 0, 2, 1'b1);
    step(1'b0, 8'h00, 1'b1, 0, 0, 1'b0);
    check("req031_clr_rerr", 32'(rerr), 32'd1);

    // Read coincident with a write
    step(1'b1, 8'h22, 1'b0, 0, 0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 0, 1, 1'b0);
`ifdef WR_FWD_EN
    check("req032_rdata0", 32'(rdata0), 32'h33);
`else
    check("req032_rdata0", 32'(rdata0), 32'h22);
`endif

    // Asynchronous reset between back-to-back reads
    step(1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, N'(8'h40 + i), 1'b0, 0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 9, 1'b0);
    rd_en = 1'b1; dly0 = 4'd1; dly1 = 4'd2;
    #2 reset = 1'b0;
    #1;
    hist.delete();
    exp_r0 = '0; exp_r1 = '0; exp_v = 1'b0; exp_e = 1'b0;
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_count",  32'(count),  32'd0);
    rd_en = 1'b0;
    @(posedge Clk);
    #3 reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), N'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), $urandom_range(0, M - 1),
           $urandom_range(0, M - 1), 1'($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_line_mem.md
DELAY_LINE_MEM -- requirements
Module: delay_line_mem

Interface
REQ-001 SHALL provide parameter N, default 8: sample width in bits.
REQ-002 SHALL provide parameter M, default 16: depth in samples; power of two, at least 4.
REQ-003 SHALL provide ports Clk (input, 1 bit): single clock, all state on rising edge.
REQ-004 SHALL provide port reset (input, 1 bit): asynchronous, active-low reset.
REQ-005 SHALL provide port clear (input, 1 bit): synchronous pointer/count clear.
REQ-006 SHALL provide port wr_en (input, 1 bit): push wdata this cycle.
REQ-007 SHALL provide port wdata (input, N bits): sample to push.
REQ-008 SHALL provide port rd_en (input, 1 bit): issue a two-tap read.
REQ-009 SHALL provide ports dly0 and dly1 (input, $clog2(M) bits each): tap delays; 0 = newest sample.
REQ-010 SHALL provide ports rdata0 and rdata1 (output, N bits each): tap data, registered.
REQ-011 SHALL provide port rvalid (output, 1 bit): rdata valid this cycle.
REQ-012 SHALL provide port rerr (output, 1 bit): a tap requested an unfilled delay.
REQ-013 SHALL provide port count (output, $clog2(M)+1 bits): samples held, saturating at M.
REQ-014 SHALL provide port full (output, 1 bit): count equals M.

Function
REQ-015 SHALL hold M words in a circular buffer with write pointer wptr, which always addresses the next location to write.
REQ-016 On wr_en, SHALL write mem[wptr] <= wdata and advance wptr by 1 modulo M (wrap from M-1 to 0); count SHALL increment, saturating at M; oldest sample overwritten when full.
REQ-017 On rd_en at cycle t, SHALL at t+1 present rdataK = mem[(wptr-1-dlyK) mod M], using wptr at t, with rvalid=1.
REQ-018 Read latency SHALL be exactly 1 cycle; back-to-back reads every cycle SHALL be supported.
REQ-019 If dlyK >= count at t, SHALL drive rdataK = 0 and rerr = 1 at t+1; the other tap SHALL remain unaffected.
REQ-020 Without rd_en, SHALL drive rvalid = 0 and rerr = 0 at t+1, and rdata0/rdata1 SHALL hold their previous values.
REQ-021 clear SHALL set wptr = 0 and count = 0 at the next edge, take priority over a same-cycle wr_en (the write is dropped), and leave memory contents unscrubbed.
REQ-022 A read in the same cycle as clear SHALL use pre-clear state.
REQ-023 full SHALL be combinational from count.

Reset
REQ-024 reset low SHALL immediately set wptr=0, count=0, all memory words=0, rdata0=rdata1=0, rvalid=0, rerr=0.
REQ-025 Reset asserted mid-stream SHALL discard any in-flight read; first valid output after release SHALL require a new rd_en.

Configuration
REQ-026 Macro WR_FWD_EN defined: a read coincident with wr_en SHALL see post-write state, i.e. delays computed from wptr+1 with wdata as delay 0 and count+1 (saturated) for the rerr check.
REQ-027 Macro WR_FWD_EN undefined: a coincident read SHALL see pre-write state per REQ-017.

Verification (N=8, M=16)
REQ-028 Reset released, no stimulus -> count=0, full=0, rdata0=rdata1=0, rvalid=0, rerr=0.
REQ-029 Write 1..5, then rd_en with dly0=0, dly1=4 -> next cycle rdata0=5, rdata1=1, rvalid=1, rerr=0, count=5.
REQ-030 Write 1..20 (wrap), then read dly0=15, dly1=0 -> rdata0=5, rdata1=20, count=16, full=1.
REQ-031 Three writes, then read dly0=5, dly1=2 -> rdata0=0, rdata1=first sample, rerr=1; clear plus wr_en 0x7F -> count=0, next read dly 0 gives rerr=1.
REQ-032 Last write 0x22, then wr_en 0x33 with rd_en dly0=0 in the same cycle -> rdata0=0x22 without WR_FWD_EN, 0x33 with it.
REQ-033 reset low between two back-to-back reads after 10 writes -> outputs zero asynchronously, count=0, no rvalid after release until a new rd_en.
